// File: rtl/jt12_pg.sv
// jt12_pg: YM2612-style phase generator, 24 time-multiplexed slots (6 channels x 4 operators)
// Ports:
//   clk         - single clock, all registers update on its rising edge
//   rst         - asynchronous active-high reset, clears pipeline and all accumulators
//   fnum        - channel frequency number (stage I)
//   block       - octave (stage I)
//   dt1_II      - detune: bit2 = subtract, bits1:0 = magnitude row (stage II)
//   mul_V       - frequency multiple, 0 means x0.5 (stage V)
//   keyon_VI    - zero the accumulator of the slot currently in stage VI
//   keycode_III - registered key code of the slot in stage III
//   phase_VIII  - registered top 10 accumulator bits of the slot in stage VIII
module jt12_pg (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] fnum,
    input  logic [2:0]  block,
    input  logic [2:0]  dt1_II,
    input  logic [3:0]  mul_V,
    input  logic        keyon_VI,
    output logic [4:0]  keycode_III,
    output logic [9:0]  phase_VIII
);
    localparam logic [4:0] dt_tab1 [32] = '{
        5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1,
        5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2,
        5'd2, 5'd3, 5'd3, 5'd3, 5'd4, 5'd4, 5'd4, 5'd5,
        5'd5, 5'd6, 5'd6, 5'd7, 5'd8, 5'd8, 5'd8, 5'd8
    };
    localparam logic [4:0] dt_tab2 [32] = '{
        5'd1,  5'd1,  5'd1,  5'd1,  5'd2,  5'd2,  5'd2,  5'd2,
        5'd2,  5'd3,  5'd3,  5'd3,  5'd4,  5'd4,  5'd4,  5'd5,
        5'd5,  5'd6,  5'd6,  5'd7,  5'd8,  5'd8,  5'd9,  5'd10,
        5'd11, 5'd12, 5'd13, 5'd14, 5'd16, 5'd16, 5'd16, 5'd16
    };
    localparam logic [4:0] dt_tab3 [32] = '{
        5'd2,  5'd2,  5'd2,  5'd2,  5'd2,  5'd3,  5'd3,  5'd3,
        5'd4,  5'd4,  5'd4,  5'd5,  5'd5,  5'd6,  5'd6,  5'd7,
        5'd8,  5'd8,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14,
        5'd16, 5'd17, 5'd19, 5'd20, 5'd22, 5'd22, 5'd22, 5'd22
    };

    logic [4:0]  kc_I, kc_II, dt_II, dt_III;
    logic [10:0] fnum_II;
    logic [2:0]  block_II;
    logic        dt_sub_III;
    logic [17:0] shifted_II;
    logic [16:0] pinc_II, pinc_III, pinc_d_IV, pinc_d_V;
    logic [19:0] inc_V, inc_VI, acc_new, phase_VII;
    logic [19:0] acc [24];

    // N3 marks the upper part of the octave for the key-scaling tables
    assign kc_I = {block, fnum[10],
                   (fnum[10] & (fnum[9] | fnum[8] | fnum[7])) | (~fnum[10] & fnum[9] & fnum[8] & fnum[7])};

    // fnum << 7 needs 18 bits before dropping the LSB
    assign shifted_II = {7'd0, fnum_II} << block_II;
    assign pinc_II    = shifted_II[17:1];

    assign dt_II = dt1_II[1:0] == 2'd0 ? 5'd0 :
                   dt1_II[1:0] == 2'd1 ? dt_tab1[kc_II] :
                   dt1_II[1:0] == 2'd2 ? dt_tab2[kc_II] : dt_tab3[kc_II];

    // mul 0 halves the increment; products above 20 bits are dropped
    assign inc_V = mul_V == 4'd0 ? {4'd0, pinc_d_V[16:1]} : {3'd0, pinc_d_V} * {16'd0, mul_V};

    // acc[23] is the value this slot wrote 24 clocks ago
    assign acc_new = keyon_VI ? 20'd0 : acc[23] + inc_VI;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kc_II       <= '0;
            fnum_II     <= '0;
            block_II    <= '0;
            keycode_III <= '0;
            pinc_III    <= '0;
            dt_III      <= '0;
            dt_sub_III  <= 1'b0;
            pinc_d_IV   <= '0;
            pinc_d_V    <= '0;
            inc_VI      <= '0;
            phase_VII   <= '0;
            phase_VIII  <= '0;
            for (int i = 0; i < 24; i++) acc[i] <= '0;
        end else begin
            kc_II       <= kc_I;
            fnum_II     <= fnum;
            block_II    <= block;
            keycode_III <= kc_II;
            pinc_III    <= pinc_II;
            dt_III      <= dt_II;
            dt_sub_III  <= dt1_II[2];
            pinc_d_IV   <= dt_sub_III ? pinc_III - {12'd0, dt_III} : pinc_III + {12'd0, dt_III};
            pinc_d_V    <= pinc_d_IV;
            inc_VI      <= inc_V;
            phase_VII   <= acc_new;
            phase_VIII  <= phase_VII[19:10];
            acc[0]      <= acc_new;
            for (int i = 1; i < 24; i++) acc[i] <= acc[i-1];
        end
    end
endmodule

// File: tb/tb_jt12_pg.sv
// tb_jt12_pg: directed table-driven bench for jt12_pg
module tb_jt12_pg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] fnum = '0;
    logic [2:0]  block = '0;
    logic [2:0]  dt1_II = '0;
    logic [3:0]  mul_V = '0;
    logic        keyon_VI = 1'b0;
    logic [4:0]  keycode_III;
    logic [9:0]  phase_VIII;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] fnum;
        logic [2:0]  block;
        logic [2:0]  dt1;
        logic [3:0]  mul;
        int          kc;
        int          inc;
        int          revs;
    } vec_t;

    vec_t vecs [11];

    jt12_pg dut (
        .clk(clk), .rst(rst), .fnum(fnum), .block(block), .dt1_II(dt1_II),
        .mul_V(mul_V), .keyon_VI(keyon_VI), .keycode_III(keycode_III), .phase_VIII(phase_VIII)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // phase_VIII seen two windows after stage VI window k; p is a key-on pulse window (-1 = none)
    function automatic int exp_phase(input int inc, input int k, input int p);
        longint a;
        if (k < 0) return 0;
        if (p >= 0 && k >= p && (k % 24) == (p % 24)) a = longint'(inc) * ((k - p) / 24);
        else a = longint'(inc) * (k / 24 + 1);
        return int'(a[19:10]);
    endfunction

    task automatic run_vec(input int idx, input int p);
        fnum = vecs[idx].fnum;
        block = vecs[idx].block;
        dt1_II = vecs[idx].dt1;
        mul_V = vecs[idx].mul;
        keyon_VI = 1'b1;
        repeat (30) @(posedge clk);
        for (int w = 0; w <= vecs[idx].revs * 24 + 1; w++) begin
            @(posedge clk);
            #1 keyon_VI = (w == p);
            @(negedge clk);
            if (w == 0) check($sformatf("kc v%0d", idx), int'(keycode_III), vecs[idx].kc);
            check($sformatf("phase v%0d p%0d w%0d", idx, p, w), int'(phase_VIII),
                  exp_phase(vecs[idx].inc, w - 2, p));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{11'd500,  3'd2, 3'd0, 4'd1,  8,  1000,   44};
        vecs[1]  = '{11'd500,  3'd2, 3'd0, 4'd0,  8,  500,    44};
        vecs[2]  = '{11'd500,  3'd2, 3'd0, 4'd3,  8,  3000,   20};
        vecs[3]  = '{11'd500,  3'd2, 3'd1, 4'd1,  8,  1001,   44};
        vecs[4]  = '{11'd500,  3'd2, 3'd5, 4'd1,  8,  999,    44};
        vecs[5]  = '{11'd500,  3'd2, 3'd3, 4'd1,  8,  1004,   44};
        vecs[6]  = '{11'd2047, 3'd7, 3'd0, 4'd15, 31, 916544, 4};
        vecs[7]  = '{11'd2047, 3'd7, 3'd3, 4'd1,  31, 131030, 10};
        vecs[8]  = '{11'd1024, 3'd0, 3'd6, 4'd2,  2,  1022,   20};
        vecs[9]  = '{11'd0,    3'd0, 3'd7, 4'd0,  0,  65535,  20};
        vecs[10] = '{11'd896,  3'd3, 3'd2, 4'd1,  13, 3588,   20};

        #3 check("rst phase", int'(phase_VIII), 0);
        check("rst kc", int'(keycode_III), 0);
        #10 check("rst phase2", int'(phase_VIII), 0);
        check("rst kc2", int'(keycode_III), 0);
        #7 rst = 1'b0;

        for (int v = 0; v < 11; v++) run_vec(v, -1);

        run_vec(0, 100);

        // asynchronous reset mid-run, then accumulation restarts from 0
        repeat (37) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("async rst phase", int'(phase_VIII), 0);
        check("async rst kc", int'(keycode_III), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 10 * 24; j++) begin
            int w;
            longint a;
            @(negedge clk);
            w = j - 2;
            a = (w < 5) ? 0 : longint'(1000) * ((w - 5) / 24 + 1);
            if (j == 3) check("post rst kc", int'(keycode_III), 8);
            check($sformatf("post rst phase j%0d", j), int'(phase_VIII), int'(a[19:10]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
